// File: rtl/wifi_link.sv
// wifi_link: UART 8N1 bridge between a serial Wi-Fi module and the alarm controller.
// Ports: clk, reset (async, active-high); uart_rx/uart_tx serial lines (idle high);
// alert/state_code status in; cmd/cmd_valid decoded remote command out;
// tx_busy while a status frame is on the line; frame_err pulses on a bad stop bit.
module wifi_link #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CMD_HOLD     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic       alert,
  input  logic [1:0] state_code,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       tx_busy,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(CMD_HOLD + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  logic [2:0]    rx_sync_q;
  uart_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [3:0]    cmd_q, cmd_d, rx_code;
  logic [HW-1:0] hold_q, hold_d;
  logic          ferr_q, ferr_d, rx_line, rx_fall, rx_bit_end, rx_new;
  uart_state_t   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, snap_q, snap_d, status;
  logic          tx_idx_q, tx_idx_d, tx_q, tx_d, busy_q, tx_bit_end;
  logic [7:0]    tx_byte;
  // rx_sync_q[1] is the synchronized line; [2] is its previous value for edge detection
  assign rx_line    = rx_sync_q[1];
  assign rx_fall    = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_bit_end = rx_cnt_q == BIT_LAST;
  assign rx_code    = rx_shift_q == 8'h44 ? 4'b1010 :
                      rx_shift_q == 8'h41 ? 4'b1011 :
                      rx_shift_q == 8'h45 ? 4'b1100 : 4'b0000;
  assign status     = {alert, state_code};
  assign tx_bit_end = tx_cnt_q == BIT_LAST;
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    ferr_d     = 1'b0;
    rx_new     = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = START;
      end
      START: if (rx_cnt_q == BIT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_line ? IDLE : DATA;
      end
      DATA: if (rx_bit_end) begin
        rx_shift_d = {rx_line, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
      end
      default: if (rx_bit_end) begin
        rx_state_d = IDLE;
        ferr_d     = ~rx_line;
        rx_new     = rx_line & (rx_code != 4'b0000);
      end
    endcase
    // a fresh command overrides whatever is being held and restarts the hold
    cmd_d  = rx_new ? rx_code : hold_q == HW'(1) ? 4'b0000 : cmd_q;
    hold_d = rx_new ? HW'(CMD_HOLD) : hold_q != '0 ? hold_q - 1'b1 : hold_q;
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_idx_d   = tx_idx_q;
    snap_d     = snap_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_idx_d = 1'b0;
        if (status != snap_q) begin
          snap_d     = status;
          tx_state_d = START;
        end
      end
      START: if (tx_bit_end) tx_state_d = DATA;
      DATA: if (tx_bit_end) begin
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) tx_state_d = STOP;
      end
      default: if (tx_bit_end) begin
        tx_state_d = tx_idx_q ? IDLE : START;
        tx_idx_d   = 1'b1;
      end
    endcase
    // the line level is registered from the next state so uart_tx never glitches
    tx_byte = tx_idx_d ? {5'b00110, snap_d} : 8'h53;
    tx_d    = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_byte[tx_bit_d] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q  <= 3'b111;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      cmd_q      <= '0;
      hold_q     <= '0;
      ferr_q     <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_idx_q   <= 1'b0;
      snap_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      cmd_q      <= cmd_d;
      hold_q     <= hold_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_idx_q   <= tx_idx_d;
      snap_q     <= snap_d;
      tx_q       <= tx_d;
      busy_q     <= tx_state_d != IDLE;
    end
  end
  assign uart_tx   = tx_q;
  assign tx_busy   = busy_q;
  assign cmd       = cmd_q;
  assign cmd_valid = |cmd_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_wifi_link.sv
// tb_wifi_link: directed bench for wifi_link with a cycle-level behavioural model.
module tb_wifi_link;
  localparam int CPB = 16;
  localparam int HOLD = 4;
  // edges from the first start-bit edge to the stop sample: 2 sync stages, half a bit, 9 bits
  localparam int STOP_LAT = 2 + CPB / 2 + 9 * CPB;
  logic clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, alert = 1'b0;
  logic [1:0] state_code = 2'b00;
  logic uart_tx, cmd_valid, tx_busy, frame_err;
  logic [3:0] cmd;
  int tests = 0, fails = 0;
  wifi_link #(.CLKS_PER_BIT(CPB), .CMD_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .alert(alert), .state_code(state_code), .cmd(cmd), .cmd_valid(cmd_valid),
    .tx_busy(tx_busy), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [3:0] code_of(input logic [7:0] b);
    return b == 8'h44 ? 4'b1010 : b == 8'h41 ? 4'b1011 : b == 8'h45 ? 4'b1100 : 4'b0000;
  endfunction
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int dec_at = -1, ferr_at = -1;
  logic [3:0] dec_code = 4'b0000;
  logic [3:0] m_cmd = 4'b0000;
  int m_hold = 0, m_rem = 0;
  logic m_ferr = 1'b0;
  logic [2:0] m_snap = 3'b000;
  logic [19:0] m_frame = '1;
  always @(posedge clk or posedge reset) begin
    int e;
    logic [7:0] b1;
    if (reset) begin
      m_cmd = 0; m_hold = 0; m_ferr = 0; m_snap = 0; m_rem = 0; dec_at = -1; ferr_at = -1;
    end else begin
      e = cyc + 1;
      if (e == dec_at) begin
        m_cmd = dec_code;
        m_hold = HOLD;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_cmd = 0;
      end
      m_ferr = e == ferr_at;
      if (m_rem > 0) m_rem--;
      else if ({alert, state_code} != m_snap) begin
        m_snap = {alert, state_code};
        b1 = 8'h30 + {5'b0, m_snap};
        m_frame = {1'b1, b1, 1'b0, 1'b1, 8'h53, 1'b0};
        m_rem = 20 * CPB;
      end
    end
  end
  always @(negedge clk) begin
    check("cmd", cmd, m_cmd);
    check("cmd_valid", cmd_valid, m_cmd != 0);
    check("frame_err", frame_err, m_ferr);
    check("tx_busy", tx_busy, m_rem > 0);
    check("uart_tx", uart_tx, m_rem > 0 ? m_frame[(20 * CPB - m_rem) / CPB] : 1'b1);
  end
  logic [3:0] q_cmd[$];
  logic [7:0] q_tx[$];
  int ferr_cnt = 0, busy_rises = 0, busy_start = 0, first_len = 0;
  logic v_prev = 1'b0, b_prev = 1'b0;
  always @(negedge clk) begin
    if (cmd_valid && !v_prev) q_cmd.push_back(cmd);
    if (frame_err) ferr_cnt++;
    if (tx_busy && !b_prev) begin
      busy_rises++;
      busy_start = cyc;
    end
    if (!tx_busy && b_prev && first_len == 0) first_len = cyc - busy_start;
    v_prev = cmd_valid;
    b_prev = tx_busy;
  end
  always begin : tx_cap
    logic [7:0] tb;
    @(negedge clk);
    if (uart_tx === 1'b0 && !reset) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        tb[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      q_tx.push_back(tb);
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(negedge clk);
    if (stop_bit && code_of(b) != 0) begin
      dec_at = cyc + 1 + STOP_LAT;
      dec_code = code_of(b);
    end
    if (!stop_bit) ferr_at = cyc + 1 + STOP_LAT;
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h44, 1);
    send_byte(8'h41, 1);
    send_byte(8'h45, 1);
    check("cmd_count_t1", q_cmd.size(), 3);
    check("cmd_disarm", q_cmd[0], 4'b1010);
    check("cmd_rearm", q_cmd[1], 4'b1011);
    check("cmd_escalate", q_cmd[2], 4'b1100);
    send_byte(8'h58, 1);
    send_byte(8'h45, 0);
    check("cmd_count_t2", q_cmd.size(), 3);
    check("ferr_count_t2", ferr_cnt, 1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    send_byte(8'h44, 1);
    check("cmd_count_t3", q_cmd.size(), 4);
    check("cmd_after_false_start", q_cmd[3], 4'b1010);
    check("ferr_count_t3", ferr_cnt, 1);
    @(negedge clk);
    alert = 1'b1;
    state_code = 2'b10;
    @(negedge clk);
    check("model_frame", m_frame, 20'h9B2A6);
    check("busy_started", tx_busy, 1);
    repeat (100) @(negedge clk);
    state_code = 2'b11;
    repeat (100) @(negedge clk);
    state_code = 2'b01;
    repeat (800) @(negedge clk);
    check("tx_byte_count", q_tx.size(), 4);
    check("tx_byte0", q_tx[0], 8'h53);
    check("tx_byte1", q_tx[1], 8'h36);
    check("tx_byte2", q_tx[2], 8'h53);
    check("tx_byte3", q_tx[3], 8'h35);
    check("frame_len", first_len, 320);
    check("tx_idle_after", uart_tx, 1);
    @(negedge clk);
    alert = 1'b0;
    state_code = 2'b01;
    uart_rx = 1'b0;
    repeat (53) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_uart_tx", uart_tx, 1);
    check("abort_tx_busy", tx_busy, 0);
    check("abort_cmd", cmd, 0);
    check("abort_cmd_valid", cmd_valid, 0);
    uart_rx = 1'b1;
    state_code = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    check("cmd_count_t6", q_cmd.size(), 4);
    check("busy_rises_t6", busy_rises, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
